// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_stage
// Description : EX/MEM pipeline stage. Captures the ALU result, store data,
//               destination register and control bits. Resolves conditional
//               branches and computes the branch target at capture time.
//               A valid/ready handshake on both sides is backed by a 2-entry
//               skid buffer (main register M drives the outputs, skid S
//               absorbs one extra entry), so in_ready is purely registered.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic        zero,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  branch_type,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] branch_offset,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_alu_result,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
);

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQZ  = 2'b01;
  localparam logic [1:0] BR_NEZ  = 2'b10;
  localparam logic [1:0] BR_ALW  = 2'b11;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        taken;
    logic [31:0] target;
  } entry_t;

  entry_t m_q, m_d, s_q, s_d, in_entry;
  logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic   in_taken, accept, fire;

  // Branch resolution and payload packing of the incoming entry
  always_comb begin
    in_taken = 1'b0;
    case (branch_type)
      BR_NONE: in_taken = 1'b0;
      BR_EQZ:  in_taken = zero;
      BR_NEZ:  in_taken = ~zero;
      BR_ALW:  in_taken = 1'b1;
      default: in_taken = 1'b0;
    endcase
    in_entry.alu       = alu_result;
    in_entry.sdata     = store_data;
    in_entry.rd        = rd;
    in_entry.reg_write = reg_write;
    in_entry.mem_read  = mem_read;
    in_entry.mem_write = mem_write;
    in_entry.taken     = in_taken;
    in_entry.target    = pc_plus4 + {branch_offset[29:0], 2'b00};
  end

  assign in_ready = ~s_valid_q;
  assign accept   = in_valid & in_ready;
  assign fire     = m_valid_q & out_ready;

  // Next-state of main and skid registers; flush beats wrong-path drop beats move/load
  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (fire && m_q.taken) begin
      // Entries behind a taken branch are on the wrong path
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || fire) begin
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else begin
        if (accept) m_d = in_entry;
        m_valid_d = accept;
      end
    end else if (accept) begin
      s_d       = in_entry;
      s_valid_d = 1'b1;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign out_valid      = m_valid_q;
  assign out_alu_result = m_q.alu;
  assign out_store_data = m_q.sdata;
  assign out_rd         = m_q.rd;
  assign out_reg_write  = m_q.reg_write;
  assign out_mem_read   = m_q.mem_read;
  assign out_mem_write  = m_q.mem_write;
  assign br_taken       = m_valid_q & m_q.taken;
  assign br_target      = m_q.target;
  assign fwd_valid      = m_valid_q & m_q.reg_write & (m_q.rd != 5'd0);
  assign fwd_rd         = m_q.rd;
  assign fwd_data       = m_q.alu;

endmodule
`default_nettype wire
